mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 16, is the number of bus-wait cycles before a grant is aborted; legal range is 2..255.
REQ-002 Parameter XLEN, default `XLEN, is the address/data width.
REQ-003 i_clk  input  1  clock; all state changes on posedge.
REQ-004 i_rst  input  1  reset, synchronous, active-low.
REQ-005 i_ic_req  input  1  instruction-cache refill request, held until o_ic_ready.
REQ-006 i_ic_addr  input  XLEN  refill word address.
REQ-007 o_ic_data  output  XLEN  refill data, valid while o_ic_ready.
REQ-008 o_ic_ready  output  1  refill complete, one-cycle pulse.
REQ-009 i_dm_read / i_dm_wen  input  1 each  data read / write request, held until o_dm_ready.
REQ-010 i_dm_addr, i_dm_wd  input  XLEN each  data address, write data.
REQ-011 i_dm_be  input  4  write byte enables.
REQ-012 o_dm_rdata  output  XLEN  read data, valid while o_dm_ready.
REQ-013 o_dm_ready  output  1  data access complete, one-cycle pulse.
REQ-014 o_bus_req, o_bus_we  output  1 each  shared-bus request, write strobe.
REQ-015 o_bus_addr, o_bus_wd  output  XLEN each  shared-bus address, write data.
REQ-016 o_bus_be  output  4  shared-bus byte enables; 4'b1111 for reads.
REQ-017 i_bus_rdata  input  XLEN  bus read data.
REQ-018 i_bus_ready  input  1  bus completion, sampled only while o_bus_req.
REQ-019 o_timeout  output  1  one-cycle pulse on an aborted grant.

Function
REQ-020 The FSM SHALL have states IDLE, GNT_IC and GNT_DM.
REQ-021 In IDLE, any sampled request SHALL move the FSM to the granted state at the next edge.
REQ-022 On grant, the requester's address, data, byte enables and write flag SHALL be latched, and all o_bus_* outputs SHALL be driven from registers (grant-to-o_bus_req latency: 1 cycle).
REQ-023 If i_dm_read and i_dm_wen are both high, the access SHALL be treated as a write.
REQ-024 While granted, i_bus_ready=1 SHALL make the owning requester's ready high combinationally in that cycle, with its rdata = i_bus_rdata.
REQ-025 In that same cycle, the other requester's ready SHALL stay 0 and its rdata SHALL be 0.
REQ-026 At the edge after i_bus_ready, the FSM SHALL go to IDLE and o_bus_req SHALL drop; minimum spacing between back-to-back grants is 1 idle cycle.
REQ-027 A wait counter SHALL clear on grant and increment each granted cycle without i_bus_ready.
REQ-028 When the counter reaches MAX_WAIT-1 without i_bus_ready, the owner's ready and o_timeout SHALL pulse together with rdata=0, and the FSM SHALL return to IDLE.
REQ-029 If i_bus_ready and the timeout condition coincide, i_bus_ready SHALL win: normal completion, no o_timeout.
REQ-030 A requester dropping its request mid-grant SHALL NOT abort the bus transaction; completion is still pulsed.

Reset
REQ-031 On reset the FSM SHALL enter IDLE, the counter SHALL clear, and the last-grant flag SHALL be set to IC.
REQ-032 On reset, o_bus_req, o_bus_we, o_ic_ready, o_dm_ready and o_timeout SHALL be 0, and o_bus_addr, o_bus_wd, o_ic_data and o_dm_rdata SHALL be 0.
REQ-033 Reset asserted mid-grant SHALL abandon the transaction silently, with no ready pulse.

Configuration
REQ-034 With ARVI_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last; the last-grant flag updates at each grant.
REQ-035 Without ARVI_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to data (fixed priority), and the last-grant flag SHALL be absent.

Structure
REQ-036 Package arvi_arb_pkg SHALL hold the state enum (IDLE/GNT_IC/GNT_DM), the grant-owner enum and the read byte-enable constant 4'b1111.
REQ-037 The wait counter and its timeout compare SHALL be a sub-module, arb_wdt (inputs clear/enable, output expired).

Verification
REQ-038 Scenario: IC request only, addr 0x100, bus ready after 3 cycles with 0xDEADBEEF -> o_bus_req 1 cycle after the request, o_ic_ready pulse with o_ic_data=0xDEADBEEF, and IDLE next cycle.
REQ-039 Scenario: IC and DM read requested in the same cycle, fixed priority -> DM served first, then IC; no overlap of o_bus_req grants.
REQ-040 Scenario: same as REQ-039 with ARVI_ARB_ROUND_ROBIN_EN, repeated 4 times -> grants alternate DM, IC, DM, IC after reset (first grant DM because the last-grant flag is IC).
REQ-041 Scenario: DM write, addr 0x2004, wd 0x55, be 4'b0001 -> o_bus_we=1, o_bus_be=0001 and o_bus_wd=0x55 held stable until ready.
REQ-042 Scenario: MAX_WAIT=4, bus never ready -> o_timeout and o_dm_ready pulse in the 4th granted cycle with o_dm_rdata=0; a further test with i_bus_ready in that same cycle shows no o_timeout.
REQ-043 Scenario: reset pulled low during GNT_IC -> o_bus_req 0 at the next edge, no o_ic_ready pulse, and the FSM in IDLE.

Source files
------------

// File: rtl/arvi_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant
// owner and the fixed byte-enable pattern used for every read.
`ifndef XLEN
`define XLEN 32
`endif

package arvi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [3:0] READ_BE = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared bus port of mem_arbiter.
// Handshake: a requester raises i_ic_req / i_dm_read / i_dm_wen with stable
// address and data and holds them until its ready pulses for one cycle; the
// arbiter raises o_bus_req with stable o_bus_* and looks at i_bus_ready only
// while o_bus_req is high.
interface mem_arbiter_if #(
  parameter int XLEN = `XLEN
);
  logic            i_ic_req;
  logic [XLEN-1:0] i_ic_addr;
  logic [XLEN-1:0] o_ic_data;
  logic            o_ic_ready;

  logic            i_dm_read;
  logic            i_dm_wen;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wd;
  logic [3:0]      i_dm_be;
  logic [XLEN-1:0] o_dm_rdata;
  logic            o_dm_ready;

  logic            o_bus_req;
  logic            o_bus_we;
  logic [XLEN-1:0] o_bus_addr;
  logic [XLEN-1:0] o_bus_wd;
  logic [3:0]      o_bus_be;
  logic [XLEN-1:0] i_bus_rdata;
  logic            i_bus_ready;
  logic            o_timeout;

  modport slave (
    input  i_ic_req, i_ic_addr, i_dm_read, i_dm_wen, i_dm_addr, i_dm_wd,
           i_dm_be, i_bus_rdata, i_bus_ready,
    output o_ic_data, o_ic_ready, o_dm_rdata, o_dm_ready, o_bus_req,
           o_bus_we, o_bus_addr, o_bus_wd, o_bus_be, o_timeout
  );

  modport master (
    output i_ic_req, i_ic_addr, i_dm_read, i_dm_wen, i_dm_addr, i_dm_wd,
           i_dm_be, i_bus_rdata, i_bus_ready,
    input  o_ic_data, o_ic_ready, o_dm_rdata, o_dm_ready, o_bus_req,
           o_bus_we, o_bus_addr, o_bus_wd, o_bus_be, o_timeout
  );
endinterface

// File: rtl/arb_wdt.sv
// Bus-wait watchdog: counts granted cycles without bus completion and flags
// expiry once MAX_WAIT-1 such cycles have elapsed since the grant.
module arb_wdt #(
  parameter int MAX_WAIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-cache refills and data accesses onto one shared bus,
// aborting a grant after MAX_WAIT cycles. Define ARVI_ARB_ROUND_ROBIN_EN for
// round-robin on simultaneous requests; otherwise data has fixed priority.
module mem_arbiter
  import arvi_arb_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int XLEN     = `XLEN
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus,
  output arb_state_e    state_dbg_o
);

  arb_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wd_q, wd_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d, req_q, req_d;
  logic            dm_req, grant_ic, grant_dm, granted, expired, done, wdt_clear;

  assign dm_req  = bus.i_dm_read | bus.i_dm_wen;
  assign granted = (state_q != IDLE);
  assign done    = granted & (bus.i_bus_ready | expired);

`ifdef ARVI_ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  // On a tie the data side wins only if instruction side was granted last.
  assign grant_dm = dm_req & (~bus.i_ic_req | (last_q == OWN_IC));
  assign grant_ic = bus.i_ic_req & ~grant_dm;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (grant_dm)      last_d = OWN_DM;
      else if (grant_ic) last_d = OWN_IC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) last_q <= OWN_IC;
    else        last_q <= last_d;
  end
`else
  assign grant_dm = dm_req;
  assign grant_ic = bus.i_ic_req & ~dm_req;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    be_d      = be_q;
    we_d      = we_q;
    req_d     = req_q;
    wdt_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d   = GNT_DM;
          addr_d    = bus.i_dm_addr;
          wd_d      = bus.i_dm_wd;
          we_d      = bus.i_dm_wen;
          be_d      = bus.i_dm_wen ? bus.i_dm_be : READ_BE;
          req_d     = 1'b1;
          wdt_clear = 1'b1;
        end else if (grant_ic) begin
          state_d   = GNT_IC;
          addr_d    = bus.i_ic_addr;
          wd_d      = '0;
          we_d      = 1'b0;
          be_d      = READ_BE;
          req_d     = 1'b1;
          wdt_clear = 1'b1;
        end
      end
      GNT_IC, GNT_DM: begin
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      we_q    <= we_d;
      req_q   <= req_d;
    end
  end

  arb_wdt #(.MAX_WAIT(MAX_WAIT)) u_wdt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .clear_i   (wdt_clear),
    .enable_i  (granted & ~bus.i_bus_ready),
    .expired_o (expired)
  );

  // Responses are gated by reset so a grant abandoned by reset never pulses.
  assign bus.o_ic_ready = i_rst & (state_q == GNT_IC) & (bus.i_bus_ready | expired);
  assign bus.o_dm_ready = i_rst & (state_q == GNT_DM) & (bus.i_bus_ready | expired);
  assign bus.o_ic_data  = (i_rst && state_q == GNT_IC && bus.i_bus_ready) ? bus.i_bus_rdata : '0;
  assign bus.o_dm_rdata = (i_rst && state_q == GNT_DM && bus.i_bus_ready) ? bus.i_bus_rdata : '0;
  assign bus.o_timeout  = i_rst & granted & expired & ~bus.i_bus_ready;

  assign bus.o_bus_req  = req_q;
  assign bus.o_bus_we   = we_q;
  assign bus.o_bus_addr = addr_q;
  assign bus.o_bus_wd   = wd_q;
  assign bus.o_bus_be   = be_q;

  assign state_dbg_o = state_q;

endmodule
